ceespu_mem_arbiter: RTL and testbench

Single-port memory arbiter for the ceespu core. It shares one synchronous RAM port between the instruction-fetch requester and the execute-stage load/store requester. Grants are issued once per cycle and reads are pipelined. Read data is routed back to its owner through a tag pipeline, and the fetch requester gets a stall indication while it is losing arbitration.

---
 rtl/ceespu_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_ceespu_mem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ceespu_mem_arbiter.sv
// rtl/ceespu_mem_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
//
// Shares one synchronous RAM port between the fetch requester and the execute-stage
// load/store requester. One grant per cycle; reads return through a {valid, owner}
// tag pipeline with a fixed latency of MEM_LAT+2 cycles from grant.
//
// Optional feature: define CEESPU_ARB_STARVE_EN to build the fetch starvation counter.
// Without it, data has strict priority over fetch.
//
// Parameters:
//   MEM_LAT     RAM read latency from registered O_mem_en to valid I_mem_rdata (1..4)
//   STARVE_MAX  consecutive refused fetch cycles before fetch is forced through (1..15)
// Ports:
//   I_clk, I_rst                      clock, synchronous active-high reset
//   I_fetch_req/addr                  fetch read request (held until granted)
//   O_fetch_gnt, O_fetch_stall        combinational grant / stall for fetch
//   O_fetch_valid, O_fetch_data       registered fetch return pulse and word
//   I_data_req/we/addr/wdata/be       load/store request (held until granted)
//   O_data_gnt                        combinational grant for data
//   O_data_valid, O_data_rdata        registered load return pulse and raw word
//   O_mem_en/we/addr/wdata            registered RAM port
//   I_mem_rdata                       RAM read data

module ceespu_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_fetch_req,
    input  logic [13:0] I_fetch_addr,
    output logic        O_fetch_gnt,
    output logic        O_fetch_stall,
    output logic        O_fetch_valid,
    output logic [31:0] O_fetch_data,
    input  logic        I_data_req,
    input  logic        I_data_we,
    input  logic [13:0] I_data_addr,
    input  logic [31:0] I_data_wdata,
    input  logic [3:0]  I_data_be,
    output logic        O_data_gnt,
    output logic        O_data_valid,
    output logic [31:0] O_data_rdata,
    output logic        O_mem_en,
    output logic [3:0]  O_mem_we,
    output logic [13:0] O_mem_addr,
    output logic [31:0] O_mem_wdata,
    input  logic [31:0] I_mem_rdata
);

    logic fetch_wins;

`ifdef CEESPU_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;

    // Counts consecutive cycles fetch was refused; reaching STARVE_MAX hands the
    // next contended cycle to fetch, and that grant clears the count.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            starve_cnt <= '0;
        end else if (!I_fetch_req || O_fetch_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign fetch_wins = (starve_cnt == CW'(STARVE_MAX));
`else
    assign fetch_wins = 1'b0;
`endif

    // Arbitration: data first unless fetch has been starved long enough.
    always_comb begin
        O_fetch_gnt = 1'b0;
        O_data_gnt  = 1'b0;
        if (!I_rst) begin
            if (I_data_req && !(I_fetch_req && fetch_wins)) begin
                O_data_gnt = 1'b1;
            end else if (I_fetch_req) begin
                O_fetch_gnt = 1'b1;
            end
        end
    end

    assign O_fetch_stall = I_fetch_req & ~O_fetch_gnt;

    logic rd_issue;
    assign rd_issue = O_fetch_gnt | (O_data_gnt & ~I_data_we);

    // Tag pipeline: stage 0 lines up with the RAM port cycle, stage MEM_LAT with
    // the cycle the RAM returns the word. Owner 1 = data, 0 = fetch.
    logic [MEM_LAT:0] tag_valid;
    logic [MEM_LAT:0] tag_owner;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_mem_en    <= 1'b0;
            O_mem_we    <= 4'b0;
            O_mem_addr  <= 14'b0;
            O_mem_wdata <= 32'b0;
            tag_valid   <= '0;
            tag_owner   <= '0;
        end else begin
            O_mem_en <= O_fetch_gnt | O_data_gnt;
            O_mem_we <= (O_data_gnt && I_data_we) ? I_data_be : 4'b0;
            // Fetch carries no write data, so wdata only moves on a data grant.
            if (O_data_gnt) begin
                O_mem_addr  <= I_data_addr;
                O_mem_wdata <= I_data_wdata;
            end else if (O_fetch_gnt) begin
                O_mem_addr  <= I_fetch_addr;
            end
            tag_valid <= {tag_valid[MEM_LAT-1:0], rd_issue};
            tag_owner <= {tag_owner[MEM_LAT-1:0], O_data_gnt};
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_fetch_valid <= 1'b0;
            O_fetch_data  <= 32'b0;
            O_data_valid  <= 1'b0;
            O_data_rdata  <= 32'b0;
        end else begin
            O_fetch_valid <= tag_valid[MEM_LAT] & ~tag_owner[MEM_LAT];
            O_data_valid  <= tag_valid[MEM_LAT] &  tag_owner[MEM_LAT];
            if (tag_valid[MEM_LAT] && !tag_owner[MEM_LAT]) begin
                O_fetch_data <= I_mem_rdata;
            end
            if (tag_valid[MEM_LAT] && tag_owner[MEM_LAT]) begin
                O_data_rdata <= I_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// tb/tb_ceespu_mem_arbiter.sv - self-checking bench for ceespu_mem_arbiter at MEM_LAT 1 and 3

module tb_ceespu_mem_arbiter;

    localparam int SM = 4;

    typedef struct packed {
        logic        fg1, dg1, fg3, dg3, stall;
        logic        fv1, dv1, fv3, dv3;
        logic [31:0] fd1, dd1, fd3, dd3;
        logic        men;
        logic [3:0]  mwe;
        logic [13:0] maddr;
        logic [31:0] mwdata;
    } obs_t;

    typedef struct packed {
        int          due;
        logic        own;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fetch_req, data_req, data_we;
    logic [13:0] fetch_addr, data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;

    logic        f_gnt1, f_stall1, f_valid1, d_gnt1, d_valid1, m_en1;
    logic [31:0] f_data1, d_rdata1, m_wdata1, m_rdata1;
    logic [3:0]  m_we1;
    logic [13:0] m_addr1;
    logic        f_gnt3, f_stall3, f_valid3, d_gnt3, d_valid3, m_en3;
    logic [31:0] f_data3, d_rdata3, m_wdata3, m_rdata3;
    logic [3:0]  m_we3;
    logic [13:0] m_addr3;

    ceespu_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(SM)) u_dut1 (
        .I_clk(clk), .I_rst(rst),
        .I_fetch_req(fetch_req), .I_fetch_addr(fetch_addr),
        .O_fetch_gnt(f_gnt1), .O_fetch_stall(f_stall1),
        .O_fetch_valid(f_valid1), .O_fetch_data(f_data1),
        .I_data_req(data_req), .I_data_we(data_we), .I_data_addr(data_addr),
        .I_data_wdata(data_wdata), .I_data_be(data_be),
        .O_data_gnt(d_gnt1), .O_data_valid(d_valid1), .O_data_rdata(d_rdata1),
        .O_mem_en(m_en1), .O_mem_we(m_we1), .O_mem_addr(m_addr1),
        .O_mem_wdata(m_wdata1), .I_mem_rdata(m_rdata1)
    );

    ceespu_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(SM)) u_dut3 (
        .I_clk(clk), .I_rst(rst),
        .I_fetch_req(fetch_req), .I_fetch_addr(fetch_addr),
        .O_fetch_gnt(f_gnt3), .O_fetch_stall(f_stall3),
        .O_fetch_valid(f_valid3), .O_fetch_data(f_data3),
        .I_data_req(data_req), .I_data_we(data_we), .I_data_addr(data_addr),
        .I_data_wdata(data_wdata), .I_data_be(data_be),
        .O_data_gnt(d_gnt3), .O_data_valid(d_valid3), .O_data_rdata(d_rdata3),
        .O_mem_en(m_en3), .O_mem_we(m_we3), .O_mem_addr(m_addr3),
        .O_mem_wdata(m_wdata3), .I_mem_rdata(m_rdata3)
    );

    function automatic logic [31:0] init_word(input logic [13:0] a);
        return {a[7:0] ^ 8'h5A, 2'b01, a, 8'hC3};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural RAMs, one per DUT, with the configured read latency.
    logic [31:0] ram1 [0:16383];
    logic [31:0] ram3 [0:16383];
    bit          w1   [0:16383];
    bit          w3   [0:16383];
    logic [31:0] rp1;
    logic [31:0] rp3 [0:2];

    always @(posedge clk) begin
        if (m_en1 && m_we1 != 4'b0) begin
            ram1[m_addr1] <= merge(w1[m_addr1] ? ram1[m_addr1] : init_word(m_addr1), m_wdata1, m_we1);
            w1[m_addr1]   <= 1'b1;
        end
        rp1 <= m_en1 ? (w1[m_addr1] ? ram1[m_addr1] : init_word(m_addr1)) : 32'h0;
    end
    assign m_rdata1 = rp1;

    always @(posedge clk) begin
        if (m_en3 && m_we3 != 4'b0) begin
            ram3[m_addr3] <= merge(w3[m_addr3] ? ram3[m_addr3] : init_word(m_addr3), m_wdata3, m_we3);
            w3[m_addr3]   <= 1'b1;
        end
        rp3[0] <= m_en3 ? (w3[m_addr3] ? ram3[m_addr3] : init_word(m_addr3)) : 32'h0;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign m_rdata3 = rp3[2];

    // Reference model: memory image, grant rule, and per-latency return queues.
    logic [31:0] mm [0:16383];
    bit          mw [0:16383];
    int          cyc;
    int          refused;
    obs_t        ereg;
    ent_t        q1[$];
    ent_t        q3[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] mrd(input logic [13:0] a);
        return mw[a] ? mm[a] : init_word(a);
    endfunction

    task automatic run_cycle(input logic r, input logic fr, input logic [13:0] fa,
                             input logic dr, input logic dwe, input logic [13:0] da,
                             input logic [31:0] dwd, input logic [3:0] dbe,
                             output obs_t o, output obs_t e);
        logic efg, edg;
        ent_t ent;
        rst = r; fetch_req = fr; fetch_addr = fa; data_req = dr; data_we = dwe;
        data_addr = da; data_wdata = dwd; data_be = dbe;
        #1;
        efg = 1'b0;
        edg = 1'b0;
        if (!r) begin
            if (fr && dr) begin
`ifdef CEESPU_ARB_STARVE_EN
                if (refused == SM) efg = 1'b1;
                else edg = 1'b1;
`else
                edg = 1'b1;
`endif
            end else begin
                efg = fr;
                edg = dr;
            end
        end
        e = ereg;
        e.fg1 = efg; e.dg1 = edg; e.fg3 = efg; e.dg3 = edg; e.stall = fr & ~efg;
        o.fg1 = f_gnt1; o.dg1 = d_gnt1; o.fg3 = f_gnt3; o.dg3 = d_gnt3; o.stall = f_stall1;
        o.fv1 = f_valid1; o.dv1 = d_valid1; o.fv3 = f_valid3; o.dv3 = d_valid3;
        o.fd1 = f_data1; o.dd1 = d_rdata1; o.fd3 = f_data3; o.dd3 = d_rdata3;
        o.men = m_en1; o.mwe = m_we1; o.maddr = m_addr1; o.mwdata = m_wdata1;
        @(posedge clk);
        if (r) begin
            ereg = '0;
            q1.delete();
            q3.delete();
            refused = 0;
        end else begin
            ereg.fv1 = 1'b0; ereg.dv1 = 1'b0; ereg.fv3 = 1'b0; ereg.dv3 = 1'b0;
            ereg.men = efg | edg;
            ereg.mwe = (edg && dwe) ? dbe : 4'b0;
            if (edg) begin
                ereg.maddr = da;
                ereg.mwdata = dwd;
            end else if (efg) begin
                ereg.maddr = fa;
            end
            if (edg && dwe) begin
                mm[da] = merge(mrd(da), dwd, dbe);
                mw[da] = 1'b1;
            end
            if (efg) begin
                q1.push_back('{cyc + 3, 1'b0, mrd(fa)});
                q3.push_back('{cyc + 5, 1'b0, mrd(fa)});
            end
            if (edg && !dwe) begin
                q1.push_back('{cyc + 3, 1'b1, mrd(da)});
                q3.push_back('{cyc + 5, 1'b1, mrd(da)});
            end
            if (efg || !fr) refused = 0;
            else refused++;
            if (q1.size() > 0 && q1[0].due == cyc + 1) begin
                ent = q1.pop_front();
                if (ent.own) begin ereg.dv1 = 1'b1; ereg.dd1 = ent.data; end
                else begin ereg.fv1 = 1'b1; ereg.fd1 = ent.data; end
            end
            if (q3.size() > 0 && q3[0].due == cyc + 1) begin
                ent = q3.pop_front();
                if (ent.own) begin ereg.dv3 = 1'b1; ereg.dd3 = ent.data; end
                else begin ereg.fv3 = 1'b1; ereg.fd3 = ent.data; end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 1'b1, 14'($urandom), 1'b1, 1'b0, 14'($urandom), $urandom, 4'hF, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, o, e); end
            n_checks++;
            if ({o.fg1, o.dg1, o.fg3, o.dg3} !== 4'b0) begin
                n_fail++; $display("FAIL reset_grants got=%b exp=0000", {o.fg1, o.dg1, o.fg3, o.dg3});
            end
        end
        run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
        n_checks++;
        if (o !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", o); end
    endtask

    task automatic test_isolated_fetch();
        obs_t o, e;
        int t_en, t_fv, n_dv;
        logic [31:0] fdat;
        run_cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h010, 32'hDEADBEEF, 4'hF, o, e);
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL iso_store cyc=%0d got=%h exp=%h", cyc, o, e); end
        run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
        t_en = -1; t_fv = -1; n_dv = 0; fdat = 32'h0;
        for (int k = 0; k < 7; k++) begin
            run_cycle(1'b0, k == 0, 14'h010, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL iso_fetch cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (k == 0) begin
                n_checks++;
                if (o.fg1 !== 1'b1) begin n_fail++; $display("FAIL iso_gnt got=%b exp=1", o.fg1); end
            end
            if (o.men === 1'b1 && t_en < 0) t_en = k;
            if (o.fv1 === 1'b1 && t_fv < 0) begin t_fv = k; fdat = o.fd1; end
            if (o.dv1 === 1'b1) n_dv++;
        end
        n_checks++;
        if (t_en != 1) begin n_fail++; $display("FAIL iso_mem_en_cycle got=%0d exp=1", t_en); end
        n_checks++;
        if (t_fv != 3) begin n_fail++; $display("FAIL iso_valid_cycle got=%0d exp=3", t_fv); end
        n_checks++;
        if (fdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iso_data got=%h exp=deadbeef", fdat); end
        n_checks++;
        if (n_dv != 0) begin n_fail++; $display("FAIL iso_data_valid got=%0d exp=0", n_dv); end
    endtask

    task automatic test_store_load();
        obs_t o, e;
        int n_dv1, n_dv3;
        logic [31:0] d1, d3;
        n_dv1 = 0; n_dv3 = 0; d1 = 32'h0; d3 = 32'h0;
        for (int k = 0; k < 11; k++) begin
            case (k)
                0: run_cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h020, 32'hAABBCCDD, 4'hF, o, e);
                1: run_cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h020, 32'h11223344, 4'b0011, o, e);
                2: run_cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h020, 32'h0, 4'hF, o, e);
                default: run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
            endcase
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL store_load cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (o.dv1 === 1'b1) begin n_dv1++; d1 = o.dd1; end
            if (o.dv3 === 1'b1) begin n_dv3++; d3 = o.dd3; end
        end
        n_checks++;
        if (n_dv1 != 1 || n_dv3 != 1) begin
            n_fail++; $display("FAIL sl_pulses got=%0d/%0d exp=1/1", n_dv1, n_dv3);
        end
        n_checks++;
        if (d1 !== 32'hAABB3344 || d3 !== 32'hAABB3344) begin
            n_fail++; $display("FAIL sl_data got=%h/%h exp=aabb3344", d1, d3);
        end
    endtask

    task automatic test_contention();
        obs_t o, e;
        int nf, nd;
        logic expf;
        nf = 0; nd = 0;
        run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
        for (int i = 1; i <= 12; i++) begin
            run_cycle(1'b0, 1'b1, 14'($urandom), 1'b1, 1'b0, 14'($urandom), 32'h0, 4'h0, o, e);
`ifdef CEESPU_ARB_STARVE_EN
            expf = (i % 5 == 0);
`else
            expf = 1'b0;
`endif
            n_checks++;
            if (o.fg1 !== expf || o.dg1 !== ~expf || o.stall !== ~expf) begin
                n_fail++; $display("FAIL contention_%0d got f=%b d=%b s=%b exp f=%b", i, o.fg1, o.dg1, o.stall, expf);
            end
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (o.fg1 === 1'b1) nf++;
            if (o.dg1 === 1'b1) nd++;
        end
`ifdef CEESPU_ARB_STARVE_EN
        n_checks++;
        if (nf != 2 || nd != 10) begin n_fail++; $display("FAIL contention_counts got=%0d/%0d exp=2/10", nf, nd); end
`else
        n_checks++;
        if (nf != 0 || nd != 12) begin n_fail++; $display("FAIL contention_counts got=%0d/%0d exp=0/12", nf, nd); end
`endif
        for (int k = 0; k < 6; k++) begin
            run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL contention_drain cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    task automatic test_interleaved();
        obs_t o, e;
        int  pc[$];
        logic po[$];
        for (int k = 0; k < 10; k++) begin
            case (k)
                0: run_cycle(1'b0, 1'b1, 14'h100, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
                1: run_cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h200, 32'h0, 4'h0, o, e);
                2: run_cycle(1'b0, 1'b1, 14'h101, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
                default: run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
            endcase
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL interleave cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (o.fv3 === 1'b1) begin pc.push_back(k); po.push_back(1'b0); end
            if (o.dv3 === 1'b1) begin pc.push_back(k); po.push_back(1'b1); end
        end
        n_checks++;
        if (pc.size() != 3) begin
            n_fail++; $display("FAIL interleave_count got=%0d exp=3", pc.size());
        end else begin
            n_checks++;
            if (pc[0] != 5 || pc[1] != 6 || pc[2] != 7 || po[0] !== 1'b0 || po[1] !== 1'b1 || po[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL interleave_order got=%0d%b %0d%b %0d%b exp=5F 6D 7F",
                         pc[0], po[0], pc[1], po[1], pc[2], po[2]);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic fr, dr, dwe;
        logic [13:0] fa, da;
        logic [31:0] dwd;
        logic [3:0] dbe;
        fr = 1'b0; dr = 1'b0; dwe = 1'b0; fa = '0; da = '0; dwd = '0; dbe = '0;
        for (int k = 0; k < 400; k++) begin
            if (!fr && $urandom_range(0, 2) != 0) begin
                fr = 1'b1; fa = 14'($urandom_range(0, 63));
            end
            if (!dr && $urandom_range(0, 1) != 0) begin
                dr = 1'b1; dwe = $urandom_range(0, 2) == 0; da = 14'($urandom_range(0, 63));
                dwd = $urandom; dbe = 4'($urandom);
            end
            run_cycle(1'b0, fr, fa, dr, dwe, da, dwd, dbe, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (e.fg1) fr = 1'b0;
            if (e.dg1) dr = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    task automatic test_reset_midflight();
        obs_t o, e;
        int npulse;
        npulse = 0;
        for (int k = 0; k < 11; k++) begin
            case (k)
                0: run_cycle(1'b0, 1'b1, 14'h030, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
                1: run_cycle(1'b0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h031, 32'h0, 4'h0, o, e);
                2: run_cycle(1'b1, 1'b1, 14'h032, 1'b1, 1'b0, 14'h033, 32'h0, 4'h0, o, e);
                default: run_cycle(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0, o, e);
            endcase
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midreset cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (k == 3) begin
                n_checks++;
                if (o !== '0) begin n_fail++; $display("FAIL midreset_zero got=%h exp=0", o); end
            end
            if (k >= 3 && (o.fv1 | o.dv1 | o.fv3 | o.dv3) !== 1'b0) npulse++;
        end
        n_checks++;
        if (npulse != 0) begin n_fail++; $display("FAIL midreset_pulses got=%0d exp=0", npulse); end
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; data_req = 1'b0; data_we = 1'b0;
        data_addr = '0; data_wdata = '0; data_be = '0;
        ereg = '0; cyc = 0; refused = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_isolated_fetch();
        test_store_load();
        test_contention();
        test_interleaved();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
